// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - level codes, hue constants, pixel record and hue phase offset helper
package video_pkg;

  localparam logic [3:0] LVL_SYNC     = 4'd0;
  localparam logic [3:0] LVL_BLANK    = 4'd1;
  localparam logic [3:0] LVL_BURST_LO = 4'd2;
  localparam logic [3:0] LVL_BURST_HI = 4'd3;
  localparam logic [3:0] LVL_LUMA_LO  = 4'd4;
  localparam logic [3:0] LVL_LUMA_HI  = 4'd5;

  localparam logic [3:0] HUE_GRAY    = 4'd0;
  localparam logic [3:0] HUE_DARK    = 4'd13;
  localparam logic [3:0] HUE_BLACK_A = 4'd14;
  localparam logic [3:0] HUE_BLACK_B = 4'd15;

  typedef struct packed {
    logic [3:0] cc;
    logic [1:0] ll;
    logic [2:0] emph;
    logic       sync;
    logic       burst;
    logic       picture;
  } pixel_t;

  localparam pixel_t PIXEL_RESET = '{cc: HUE_BLACK_B, ll: 2'd0, emph: 3'd0,
                                     sync: 1'b0, burst: 1'b0, picture: 1'b0};

  // Hues outside 1..12 have no chroma; they map to offset 0 so the window is still defined.
  function automatic logic [15:0] hue_offset(input logic [3:0] h, input int phases, input logic alt);
    logic [15:0] off;
    off = 16'd0;
    if (h >= 4'd1 && h <= 4'd12)
      off = 16'((int'(h) - 1) * (phases / 12));
    if (alt && off != 16'd0)
      off = 16'(phases) - off;
    return off;
  endfunction

endpackage

// File: rtl/video_hue_window.sv
// rtl/video_hue_window.sv - true while the subcarrier phase is in the positive half-cycle of a hue
module video_hue_window
  import video_pkg::*;
#(
  parameter int PHASES = 12
) (
  input  logic [3:0]                i_hue,
  input  logic [$clog2(PHASES)-1:0] i_phase,
  input  logic                      i_alt,
  output logic                      o_win
);

  localparam int PW = $clog2(PHASES);
  localparam int WW = PW + 1;
  localparam logic [WW-1:0] P_W    = WW'(PHASES);
  localparam logic [WW-1:0] HALF_W = WW'(PHASES / 2);

  logic [WW-1:0] w_off;
  logic [WW-1:0] w_sum;
  logic [WW-1:0] w_diff;

  assign w_off = WW'(hue_offset(i_hue, PHASES, i_alt));

  // Biasing by PHASES keeps the subtraction non-negative, so one conditional subtract is the modulo.
  assign w_sum  = {1'b0, i_phase} + P_W - w_off;
  assign w_diff = (w_sum >= P_W) ? w_sum - P_W : w_sum;
  assign o_win  = (w_diff < HALF_W);

endmodule

// File: rtl/video_gen_param.sv
// rtl/video_gen_param.sv - parametrised composite-video level generator with pixel strobe
module video_gen_param
  import video_pkg::*;
#(
  parameter int PHASES     = 12,
  parameter int PIX_DIV    = 8,
  parameter int PAL_ALT    = 0,
  parameter int BURST_HUE  = 8,
  parameter int EMPH_R_HUE = 4,
  parameter int EMPH_G_HUE = 8,
  parameter int EMPH_B_HUE = 12
) (
  input  logic                      CLK,
  input  logic                      RES,
  input  logic                      line_start,
  input  logic [3:0]                cc,
  input  logic [1:0]                ll,
  input  logic [2:0]                emph,
  input  logic                      sync,
  input  logic                      burst,
  input  logic                      picture,
  output logic                      pix_stb,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic [3:0]                vout_level,
  output logic                      tint
);

  localparam int PW = $clog2(PHASES);
  localparam int CW = $clog2(PIX_DIV);

  logic [PW-1:0] r_phase;
  logic [CW-1:0] r_pix_cnt;
  logic          r_alt;
  pixel_t        r_pix;
  logic [3:0]    r_level;
  logic          r_tint;

  logic       w_win_pix;
  logic       w_win_burst;
  logic       w_win_r;
  logic       w_win_g;
  logic       w_win_b;
  logic [3:0] w_luma_lo;
  logic [3:0] w_luma_hi;

  assign pix_stb = (r_pix_cnt == CW'(PIX_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_phase   <= '0;
      r_pix_cnt <= '0;
      r_alt     <= 1'b0;
      r_pix     <= PIXEL_RESET;
    end else begin
      r_phase   <= (r_phase == PW'(PHASES - 1)) ? '0 : r_phase + PW'(1);
      r_pix_cnt <= pix_stb ? '0 : r_pix_cnt + CW'(1);
      if (PAL_ALT != 0 && line_start)
        r_alt <= ~r_alt;
      if (pix_stb)
        r_pix <= '{cc: cc, ll: ll, emph: emph, sync: sync, burst: burst, picture: picture};
    end
  end

  video_hue_window #(.PHASES(PHASES)) u_win_pix (
    .i_hue(r_pix.cc), .i_phase(r_phase), .i_alt(r_alt), .o_win(w_win_pix));
  video_hue_window #(.PHASES(PHASES)) u_win_burst (
    .i_hue(4'(BURST_HUE)), .i_phase(r_phase), .i_alt(r_alt), .o_win(w_win_burst));
  video_hue_window #(.PHASES(PHASES)) u_win_r (
    .i_hue(4'(EMPH_R_HUE)), .i_phase(r_phase), .i_alt(r_alt), .o_win(w_win_r));
  video_hue_window #(.PHASES(PHASES)) u_win_g (
    .i_hue(4'(EMPH_G_HUE)), .i_phase(r_phase), .i_alt(r_alt), .o_win(w_win_g));
  video_hue_window #(.PHASES(PHASES)) u_win_b (
    .i_hue(4'(EMPH_B_HUE)), .i_phase(r_phase), .i_alt(r_alt), .o_win(w_win_b));

  assign w_luma_lo = LVL_LUMA_LO + {1'b0, r_pix.ll, 1'b0};
  assign w_luma_hi = LVL_LUMA_HI + {1'b0, r_pix.ll, 1'b0};

  // Re-evaluated every clock from the held pixel, so chroma keeps toggling within a pixel.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_level <= LVL_BLANK;
      r_tint  <= 1'b0;
    end else begin
      r_tint <= r_pix.picture & ~r_pix.sync & ~r_pix.burst &
                (|(r_pix.emph & {w_win_b, w_win_g, w_win_r}));
      if (r_pix.sync)
        r_level <= LVL_SYNC;
      else if (r_pix.burst)
        r_level <= w_win_burst ? LVL_BURST_HI : LVL_BURST_LO;
      else if (!r_pix.picture || r_pix.cc == HUE_BLACK_A || r_pix.cc == HUE_BLACK_B)
        r_level <= LVL_BLANK;
      else if (r_pix.cc == HUE_GRAY)
        r_level <= w_luma_hi;
      else if (r_pix.cc == HUE_DARK)
        r_level <= w_luma_lo;
      else
        r_level <= w_win_pix ? w_luma_hi : w_luma_lo;
    end
  end

  assign phase      = r_phase;
  assign vout_level = r_level;
  assign tint       = r_tint;

endmodule

// File: tb/tb_video_gen_param.sv
// tb/tb_video_gen_param.sv - bench for video_gen_param: NTSC-style and PAL-alternating instances
module tb_video_gen_param;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       line_start = 1'b0;
  logic [3:0] cc = 4'd15;
  logic [1:0] ll = 2'd0;
  logic [2:0] emph = 3'd0;
  logic       sync = 1'b0;
  logic       burst = 1'b0;
  logic       picture = 1'b0;

  logic       a_stb, b_stb;
  logic [3:0] a_phase;
  logic [4:0] b_phase;
  logic [3:0] a_lv, b_lv;
  logic       a_tint, b_tint;

  always #5 CLK = ~CLK;

  video_gen_param #(.PHASES(12), .PIX_DIV(8), .PAL_ALT(0), .BURST_HUE(8),
                    .EMPH_R_HUE(4), .EMPH_G_HUE(8), .EMPH_B_HUE(12)) u_dut_a (
    .CLK(CLK), .RES(RES), .line_start(line_start), .cc(cc), .ll(ll), .emph(emph),
    .sync(sync), .burst(burst), .picture(picture),
    .pix_stb(a_stb), .phase(a_phase), .vout_level(a_lv), .tint(a_tint));

  video_gen_param #(.PHASES(24), .PIX_DIV(5), .PAL_ALT(1), .BURST_HUE(3),
                    .EMPH_R_HUE(2), .EMPH_G_HUE(6), .EMPH_B_HUE(11)) u_dut_b (
    .CLK(CLK), .RES(RES), .line_start(line_start), .cc(cc), .ll(ll), .emph(emph),
    .sync(sync), .burst(burst), .picture(picture),
    .pix_stb(b_stb), .phase(b_phase), .vout_level(b_lv), .tint(b_tint));

  typedef struct { int cc; int ll; int emph; int sync; int burst; int picture; } pix_m_t;

  int n_pass  = 0;
  int n_total = 0;
  int t       = 0;
  int m_p[2]    = '{12, 24};
  int m_d[2]    = '{8, 5};
  int m_palt[2] = '{0, 1};
  int m_bh[2]   = '{8, 3};
  int m_eh[2][3] = '{'{4, 8, 12}, '{2, 6, 11}};
  pix_m_t held[2];
  int     alt_m[2];

  function automatic int win(int h, int ph, int alt, int p);
    int off;
    off = (h - 1) * p / 12;
    if (alt != 0) off = (p - off) % p;
    return (((ph - off) % p + p) % p) < p / 2 ? 1 : 0;
  endfunction

  function automatic int exp_level(pix_m_t x, int ph, int alt, int d);
    int lo;
    lo = 4 + 2 * x.ll;
    if (x.sync != 0) return 0;
    if (x.burst != 0) return (win(m_bh[d], ph, alt, m_p[d]) != 0) ? 3 : 2;
    if (x.picture == 0 || x.cc >= 14) return 1;
    if (x.cc == 0) return lo + 1;
    if (x.cc == 13) return lo;
    return (win(x.cc, ph, alt, m_p[d]) != 0) ? lo + 1 : lo;
  endfunction

  function automatic int exp_tint(pix_m_t x, int ph, int alt, int d);
    if (x.picture == 0 || x.sync != 0 || x.burst != 0) return 0;
    for (int c = 0; c < 3; c++)
      if (((x.emph >> c) & 1) != 0 && win(m_eh[d][c], ph, alt, m_p[d]) != 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d at t=%0d", tag, obs, exp, t);
  endtask

  task automatic set_pix(input int c, input int l, input int e, input int s, input int b, input int p);
    cc      = 4'(c);
    ll      = 2'(l);
    emph    = 3'(e);
    sync    = (s != 0);
    burst   = (b != 0);
    picture = (p != 0);
  endtask

  task automatic reset_model();
    t = 0;
    for (int d = 0; d < 2; d++) begin
      held[d]  = '{15, 0, 0, 0, 0, 0};
      alt_m[d] = 0;
    end
  endtask

  // One clock: predict outputs from the pre-edge state, advance the model, then compare.
  task automatic step();
    int e_lv[2];
    int e_tn[2];
    for (int d = 0; d < 2; d++) begin
      if (RES) begin
        e_lv[d] = 1;
        e_tn[d] = 0;
      end else begin
        e_lv[d] = exp_level(held[d], t % m_p[d], alt_m[d], d);
        e_tn[d] = exp_tint(held[d], t % m_p[d], alt_m[d], d);
      end
    end
    @(posedge CLK);
    if (RES) begin
      reset_model();
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (t % m_d[d] == m_d[d] - 1)
          held[d] = '{int'(cc), int'(ll), int'(emph), int'(sync), int'(burst), int'(picture)};
        if (m_palt[d] != 0 && line_start) alt_m[d] = 1 - alt_m[d];
      end
      t++;
    end
    #1;
    chk("level_a", 8'(a_lv), 8'(e_lv[0]));
    chk("tint_a", 8'(a_tint), 8'(e_tn[0]));
    chk("phase_a", 8'(a_phase), 8'(t % m_p[0]));
    chk("stb_a", 8'(a_stb), 8'((t % m_d[0]) == m_d[0] - 1));
    chk("level_b", 8'(b_lv), 8'(e_lv[1]));
    chk("tint_b", 8'(b_tint), 8'(e_tn[1]));
    chk("phase_b", 8'(b_phase), 8'(t % m_p[1]));
    chk("stb_b", 8'(b_stb), 8'((t % m_d[1]) == m_d[1] - 1));
  endtask

  initial begin
    reset_model();
    RES = 1'b1;
    repeat (3) step();
    RES = 1'b0;
    repeat (16) step();

    set_pix(1, 2, 0, 0, 0, 1);
    repeat (32) step();
    set_pix(1, 2, 0, 1, 1, 1);
    repeat (16) step();
    set_pix(1, 2, 0, 0, 1, 1);
    repeat (32) step();
    set_pix(14, 0, 1, 0, 0, 1);
    repeat (32) step();
    set_pix(14, 0, 1, 0, 0, 0);
    repeat (16) step();
    set_pix(0, 3, 0, 0, 0, 1);
    repeat (16) step();
    set_pix(13, 1, 6, 0, 0, 1);
    repeat (16) step();

    set_pix(3, 1, 0, 0, 0, 1);
    repeat (30) step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (30) step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    repeat (30) step();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0)
        set_pix(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 5) == 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0);
      line_start = ($urandom_range(0, 24) == 0);
      step();
    end
    line_start = 1'b0;

    set_pix(5, 3, 7, 0, 0, 1);
    repeat (16) step();
    for (int k = 0; k < 8 && (t % 8) != 4; k++) step();
    RES = 1'b1;
    step();
    RES = 1'b0;
    set_pix(14, 0, 0, 0, 0, 0);
    repeat (24) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
